// File: rtl/anti_rebond.sv
// Two-channel push-button debouncer with one-cycle press pulses and an
// auto-repeat pulse train on channel 0 while its button stays held.
module anti_rebond #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] btn_n,
    output logic [1:0] clean_n,
    output logic [1:0] press,
    output logic       repeat0
);

    localparam int unsigned CntW = 25;

    localparam logic [CntW-1:0] DbLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] RdLast  = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RpLast  = CntW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StWait, StRpt} rpt_state_e;

    logic [1:0]      s1_q, s2_q;
    logic [1:0]      clean_q, clean_d;
    logic [1:0]      press_q, press_d;
    logic [CntW-1:0] db_cnt_q [2];
    logic [CntW-1:0] db_cnt_d [2];

    rpt_state_e      state_q, state_d;
    logic [CntW-1:0] rpt_cnt_q, rpt_cnt_d;

    // Debounce next-state: a differing level must persist DEBOUNCE_CYCLES
    // synchronized cycles; any return to the accepted level restarts the count.
    always_comb begin
        clean_d = clean_q;
        press_d = 2'b00;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (s2_q[i] == clean_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbLast) begin
                clean_d[i]  = s2_q[i];
                press_d[i]  = ~s2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= 2'b11;
            s2_q     <= 2'b11;
            clean_q  <= 2'b11;
            press_q  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= btn_n;
            s2_q     <= s1_q;
            clean_q  <= clean_d;
            press_q  <= press_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // Auto-repeat FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    // Auto-repeat FSM: next state
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        unique case (state_q)
            StIdle: begin
                rpt_cnt_d = '0;
                if (press_q[0]) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (clean_q[0]) begin
                    state_d   = StIdle;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == RdLast) begin
                    state_d   = StRpt;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            StRpt: begin
                if (clean_q[0]) begin
                    state_d   = StIdle;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == RpLast) begin
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                rpt_cnt_d = '0;
            end
        endcase
    end

    // Auto-repeat FSM: outputs. A release suppresses the pulse on the exit cycle.
    always_comb begin
        repeat0 = 1'b0;
        if (!clean_q[0]) begin
            if (state_q == StWait && rpt_cnt_q == RdLast) begin
                repeat0 = 1'b1;
            end else if (state_q == StRpt && rpt_cnt_q == RpLast) begin
                repeat0 = 1'b1;
            end
        end
    end

    assign clean_n = clean_q;
    assign press   = press_q;

endmodule

// File: doc/anti_rebond.md
ANTI_REBOND -- requirements
Module: anti_rebond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive stable cycles required before a level change is accepted (5 ms at 50 MHz); legal range 2..2^25-1.
REQ-002 Parameter REPEAT_DELAY, default 25000000, is the number of cycles from press pulse to first auto-repeat pulse on channel 0; legal range 2..2^25-1.
REQ-003 Parameter REPEAT_PERIOD, default 10000000, is the number of cycles between successive auto-repeat pulses on channel 0; legal range 2..2^25-1.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 btn_n  input  2  raw asynchronous push-buttons, 0 when pressed; bit0 = suivant, bit1 = lancer.
REQ-007 clean_n  output  2  debounced level per channel, 0 when pressed; drives suivant_n / lancer_n of the dice top level.
REQ-008 press  output  2  one-cycle pulse per channel on each accepted press.
REQ-009 repeat0  output  1  one-cycle auto-repeat pulse, channel 0 only.

Function
REQ-010 Each channel SHALL pass btn_n through a 2-flop synchronizer (s1 <= btn_n, s2 <= s1) before any other use.
REQ-011 Each channel SHALL hold a debounce counter: s2 == clean_n -> counter cleared; s2 != clean_n and counter == DEBOUNCE_CYCLES-1 -> clean_n <= s2, counter cleared; otherwise counter +1.
REQ-012 Latency: a raw level held stable SHALL appear on clean_n at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new level as edge 1.
REQ-013 Any raw excursion shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave clean_n unchanged and restart the count on the next excursion.
REQ-014 press[i] SHALL be 1 for exactly the one cycle in which clean_n[i] first reads 0 after reading 1; it SHALL never assert on release.
REQ-015 Channel 0 auto-repeat FSM, states IDLE / WAIT / RPT, with a repeat counter:
 - IDLE: on press[0] -> WAIT, counter 0.
 - WAIT: clean_n[0]==0 -> counter +1; at counter == REPEAT_DELAY-1 -> repeat0 pulses next cycle, -> RPT, counter 0.
 - RPT: counter +1; at counter == REPEAT_PERIOD-1 -> repeat0 pulses next cycle, counter 0.
 - WAIT or RPT with clean_n[0]==1 -> IDLE same edge, counter 0, no pulse.
REQ-016 The first repeat0 pulse SHALL occur exactly REPEAT_DELAY cycles after the press[0] pulse; subsequent pulses every REPEAT_PERIOD cycles while held.
REQ-017 repeat0 and press[0] SHALL never assert in the same cycle.
REQ-018 Channels SHALL be fully independent; simultaneous presses on both SHALL produce press = 2'b11 in the same cycle when raw edges coincide.
REQ-019 All counters SHALL be 25 bits wide and SHALL never wrap; each clears on reaching its terminal value.

Reset
REQ-020 With rst_n == 0 at a rising edge: s1, s2, clean_n = 2'b11; press = 2'b00; repeat0 = 0; FSM = IDLE; all counters 0.
REQ-021 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse; a button still held at reset release SHALL be accepted as a new press after full debounce latency.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=6, REPEAT_PERIOD=3)
REQ-022 btn_n[0] 1->0 held -> clean_n[0] falls at edge 6 after change, press[0]=1 for one cycle at edge 6, press[1]=0 throughout.
REQ-023 btn_n[1] 0-pulses of 3 cycles repeated with 1-cycle high gaps -> clean_n[1] stays 1, press[1] never asserts.
REQ-024 btn_n[0] held low 20 cycles after press[0] -> repeat0 pulses at +6, +9, +12, +15, +18 cycles after press[0]; release -> no further pulses, FSM IDLE.
REQ-025 btn_n = 2'b00 applied on the same edge -> press = 2'b11 in one cycle, then 2'b00.
REQ-026 rst_n low for 1 cycle 2 cycles after the first repeat0, button held -> repeat0 stops, clean_n = 2'b11 after reset, press[0] reasserts 6 edges after reset release, first repeat0 6 cycles after that.
